// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and packet types for the completion-bus arbiter.
// FU results, ROB update packets and CDB broadcast packets all live here.
package cdb_arbiter_pkg;

    localparam int ROBN_W           = 5;
    localparam int PRN_W            = 6;
    localparam int XLEN             = 32;
    localparam int FU_ROB_PACKET_SZ = 2;
    localparam int NUM_FU_CDB       = 8;

    typedef struct packed {
        logic [ROBN_W-1:0] robn;
        logic [PRN_W-1:0]  dest_prn;
        logic [XLEN-1:0]   value;
        logic              branch_taken;
        logic [XLEN-1:0]   target_addr;
    } CDB_REQ;

    typedef struct packed {
        logic              executed;
        logic [ROBN_W-1:0] robn;
        logic              branch_taken;
        logic [XLEN-1:0]   target_addr;
    } FU_ROB_PACKET;

    typedef struct packed {
        logic             valid;
        logic [PRN_W-1:0] dest_prn;
        logic [XLEN-1:0]  value;
    } CDB_PACKET;

endpackage

// File: rtl/cdb_arbiter_rr_multi_picker.sv
// Combinational round-robin picker: selects up to CDB_SZ requesters starting at ptr
// and reports which slot each winner lands in plus the pointer after the last winner.
module rr_multi_picker #(
    parameter int NUM_FU = 8,
    parameter int CDB_SZ = 2,
    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic [NUM_FU-1:0]             req,
    input  logic [PTR_W-1:0]              ptr,
    output logic [NUM_FU-1:0]             grant,
    output logic [CDB_SZ-1:0][PTR_W-1:0]  slot_idx,
    output logic [CDB_SZ-1:0]             slot_vld,
    output logic [PTR_W-1:0]              next_ptr
);

    // Modulo add by compare-and-subtract so NUM_FU need not be a power of two.
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
        logic [PTR_W:0] s;
        s = {1'b0, base} + (PTR_W+1)'(off);
        if (s >= (PTR_W+1)'(NUM_FU)) begin
            s = s - (PTR_W+1)'(NUM_FU);
        end else begin
            s = s;
        end
        return s[PTR_W-1:0];
    endfunction

    // Scan from ptr; the k-th valid requester found goes to slot k until slots run out.
    always_comb begin
        int               rank;
        logic [PTR_W-1:0] idx;
        grant    = '0;
        slot_idx = '0;
        slot_vld = '0;
        next_ptr = ptr;
        rank     = 0;
        idx      = '0;
        for (int o = 0; o < NUM_FU; o++) begin
            idx = wrap_idx(ptr, o);
            if (req[idx] && (rank < CDB_SZ)) begin
                grant[idx] = 1'b1;
                for (int k = 0; k < CDB_SZ; k++) begin
                    slot_idx[k] = (k == rank) ? idx : slot_idx[k];
                    slot_vld[k] = slot_vld[k] | (k == rank);
                end
                next_ptr = wrap_idx(idx, 1);
                rank     = rank + 1;
            end else begin
                rank = rank;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Completion-bus arbiter: round-robin picks up to CDB_SZ FU results per cycle and
// registers them as ROB update and CDB broadcast packets; squash drops the cycle.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU = NUM_FU_CDB,
    parameter int CDB_SZ = FU_ROB_PACKET_SZ,
    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      squash,
    input  logic [NUM_FU-1:0]         fu_req_valid,
    input  CDB_REQ [NUM_FU-1:0]       fu_req,
    output logic [NUM_FU-1:0]         fu_grant,
    output FU_ROB_PACKET [CDB_SZ-1:0] fu_rob_packet,
    output CDB_PACKET [CDB_SZ-1:0]    cdb_packet,
    output logic [PTR_W-1:0]          rr_ptr_out
);

    logic [PTR_W-1:0]             r_ptr;
    FU_ROB_PACKET [CDB_SZ-1:0]    r_rob;
    CDB_PACKET [CDB_SZ-1:0]       r_cdb;

    logic [NUM_FU-1:0]            w_req;
    logic [NUM_FU-1:0]            w_grant;
    logic [CDB_SZ-1:0][PTR_W-1:0] w_slot_idx;
    logic [CDB_SZ-1:0]            w_slot_vld;
    logic [PTR_W-1:0]             w_next_ptr;

    // Masking requests here keeps grants low through reset and squash without extra state.
    assign w_req = (reset || squash) ? '0 : fu_req_valid;

    rr_multi_picker #(
        .NUM_FU (NUM_FU),
        .CDB_SZ (CDB_SZ)
    ) u_picker (
        .req      (w_req),
        .ptr      (r_ptr),
        .grant    (w_grant),
        .slot_idx (w_slot_idx),
        .slot_vld (w_slot_vld),
        .next_ptr (w_next_ptr)
    );

    // Output slots reload every cycle; empty slots carry all-zero packets.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr <= '0;
            r_rob <= '0;
            r_cdb <= '0;
        end else if (squash) begin
            r_ptr <= r_ptr;
            r_rob <= '0;
            r_cdb <= '0;
        end else begin
            r_ptr <= (|w_slot_vld) ? w_next_ptr : r_ptr;
            for (int k = 0; k < CDB_SZ; k++) begin
                if (w_slot_vld[k]) begin
                    r_rob[k].executed     <= 1'b1;
                    r_rob[k].robn         <= fu_req[w_slot_idx[k]].robn;
                    r_rob[k].branch_taken <= fu_req[w_slot_idx[k]].branch_taken;
                    r_rob[k].target_addr  <= fu_req[w_slot_idx[k]].target_addr;
                    // A winner without a destination still retires in the ROB but wakes nobody.
                    r_cdb[k].valid        <= (fu_req[w_slot_idx[k]].dest_prn != '0);
                    r_cdb[k].dest_prn     <= fu_req[w_slot_idx[k]].dest_prn;
                    r_cdb[k].value        <= fu_req[w_slot_idx[k]].value;
                end else begin
                    r_rob[k] <= '0;
                    r_cdb[k] <= '0;
                end
            end
        end
    end

    assign fu_grant      = w_grant;
    assign fu_rob_packet = r_rob;
    assign cdb_packet    = r_cdb;
    assign rr_ptr_out    = r_ptr;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter (NUM_FU=4, CDB_SZ=2): directed scenarios then
// random FU traffic, checked against a queue-based round-robin reference model.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NF = 4;
    localparam int CS = 2;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  squash;
    logic [NF-1:0]         fu_req_valid;
    CDB_REQ [NF-1:0]       fu_req;
    logic [NF-1:0]         fu_grant;
    FU_ROB_PACKET [CS-1:0] fu_rob_packet;
    CDB_PACKET [CS-1:0]    cdb_packet;
    logic [1:0]            rr_ptr_out;

    typedef struct packed {
        FU_ROB_PACKET [CS-1:0] rob;
        CDB_PACKET [CS-1:0]    cdb;
        logic [1:0]            ptr;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   got;
    int     vectors     = 0;
    int     miscompares = 0;
    int     m_ptr       = 0;
    logic   pend[NF];
    CDB_REQ req_tab[NF];

    cdb_arbiter #(.NUM_FU(NF), .CDB_SZ(CS)) dut (
        .clock         (clock),
        .reset         (reset),
        .squash        (squash),
        .fu_req_valid  (fu_req_valid),
        .fu_req        (fu_req),
        .fu_grant      (fu_grant),
        .fu_rob_packet (fu_rob_packet),
        .cdb_packet    (cdb_packet),
        .rr_ptr_out    (rr_ptr_out)
    );

    always #5 clock = ~clock;

    function automatic CDB_REQ mk_req(input logic [4:0] robn, input logic [5:0] dest);
        CDB_REQ r;
        r.robn         = robn;
        r.dest_prn     = dest;
        r.value        = $urandom;
        r.branch_taken = 1'($urandom_range(0, 1));
        r.target_addr  = $urandom;
        return r;
    endfunction

    // One cycle: drive the FUs' held requests, predict grants and next-cycle outputs.
    task automatic step(input logic rs, input logic sq);
        int            winners[$];
        exp_t          e;
        logic [NF-1:0] eg;
        @(posedge clock);
        #2;
        reset  = rs;
        squash = sq;
        for (int i = 0; i < NF; i++) begin
            fu_req_valid[i] = pend[i];
            fu_req[i]       = req_tab[i];
        end
        #1;
        e  = '0;
        eg = '0;
        if (rs) begin
            m_ptr = 0;
        end else if (!sq) begin
            for (int o = 0; o < NF; o++) begin
                if (pend[(m_ptr + o) % NF] && winners.size() < CS)
                    winners.push_back((m_ptr + o) % NF);
            end
            for (int k = 0; k < winners.size(); k++) begin
                eg[winners[k]]          = 1'b1;
                e.rob[k].executed       = 1'b1;
                e.rob[k].robn           = req_tab[winners[k]].robn;
                e.rob[k].branch_taken   = req_tab[winners[k]].branch_taken;
                e.rob[k].target_addr    = req_tab[winners[k]].target_addr;
                e.cdb[k].valid          = (req_tab[winners[k]].dest_prn != 6'd0);
                e.cdb[k].dest_prn       = req_tab[winners[k]].dest_prn;
                e.cdb[k].value          = req_tab[winners[k]].value;
            end
            if (winners.size() > 0)
                m_ptr = (winners[winners.size() - 1] + 1) % NF;
        end
        e.ptr = m_ptr[1:0];
        vectors++;
        if (fu_grant !== eg) begin
            miscompares++;
            $display("FAIL grant t=%0t: got %b expected %b", $time, fu_grant, eg);
        end
        exp_q.push_back(e);
        for (int i = 0; i < NF; i++)
            if (rs || sq || eg[i]) pend[i] = 1'b0;
    endtask

    // Monitor: registered outputs settle 1 time unit after the edge.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                got = exp_q.pop_front();
                vectors++;
                if ({fu_rob_packet, cdb_packet, rr_ptr_out} !== {got.rob, got.cdb, got.ptr}) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t: got rob=%h cdb=%h ptr=%0d expected rob=%h cdb=%h ptr=%0d",
                             $time, fu_rob_packet, cdb_packet, rr_ptr_out, got.rob, got.cdb, got.ptr);
                end
            end
        end
    end

    initial begin
        int steps;
        reset        = 1'b1;
        squash       = 1'b0;
        fu_req_valid = '0;
        fu_req       = '0;
        for (int i = 0; i < NF; i++) begin
            pend[i]    = 1'b0;
            req_tab[i] = '0;
        end

        // Reset with every FU requesting: no grants, outputs zero.
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < NF; i++) begin
                pend[i]    = 1'b1;
                req_tab[i] = mk_req(5'(i), 6'(i + 1));
            end
            step(1'b1, 1'b0);
        end

        // Rotation: all four held for three cycles.
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < NF; i++) begin
                if (!pend[i]) req_tab[i] = mk_req(5'(4 * c + i + 1), 6'(10 + i));
                pend[i] = 1'b1;
            end
            step(1'b0, 1'b0);
        end
        for (int i = 0; i < NF; i++) pend[i] = 1'b0;

        // Sparse wrap: move pointer to 3, then FU3 and FU0 request.
        pend[2] = 1'b1; req_tab[2] = mk_req(5'd20, 6'd21);
        step(1'b0, 1'b0);
        pend[0] = 1'b1; req_tab[0] = mk_req(5'd22, 6'd23);
        pend[3] = 1'b1; req_tab[3] = mk_req(5'd24, 6'd25);
        step(1'b0, 1'b0);

        // Hold until grant: robn 5..8, each FU keeps valid until granted.
        for (int i = 0; i < NF; i++) begin
            pend[i]    = 1'b1;
            req_tab[i] = mk_req(5'(5 + i), 6'(30 + i));
        end
        steps = 0;
        while ((pend[0] || pend[1] || pend[2] || pend[3]) && steps < 8) begin
            step(1'b0, 1'b0);
            steps++;
        end

        // Squash with FU1/FU2 pending, then an idle cycle.
        pend[1] = 1'b1; req_tab[1] = mk_req(5'd9, 6'd40);
        pend[2] = 1'b1; req_tab[2] = mk_req(5'd10, 6'd41);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);

        // No destination: ROB slot filled, CDB slot invalid.
        pend[1] = 1'b1; req_tab[1] = mk_req(5'd12, 6'd0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Random traffic with occasional squash and reset.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NF; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i]    = 1'b1;
                    req_tab[i] = mk_req(5'($urandom),
                                        ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63)));
                end
            end
            step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
        end

        @(posedge clock);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected outputs never observed, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin completion-bus arbiter between the functional units and the ROB/CDB. Each cycle it grants up to `CDB_SZ` of `NUM_FU` pending FU completions. It registers the winners onto `fu_rob_packet` for ROB executed/branch-resolve update, and onto `cdb_packet` for RS wakeup and PRF write. On squash it drops all in-flight completions.

## Interface
- `NUM_FU`, default 8: number of FU completion requesters.
- `CDB_SZ`, default `` `FU_ROB_PACKET_SZ ``: completion slots per cycle.
- `clock`, input, 1: clock.
- `reset`, input, 1: synchronous, active-high.
- `squash`, input, 1: ROB squash; flush this cycle.
- `fu_req_valid`, input, `[NUM_FU-1:0]`: FU has a finished result.
- `fu_req`, input, `CDB_REQ [NUM_FU-1:0]`: fields `{robn, dest_prn, value, branch_taken, target_addr}`.
- `fu_grant`, output, `[NUM_FU-1:0]`: combinational; result taken this cycle.
- `fu_rob_packet`, output, `FU_ROB_PACKET [CDB_SZ-1:0]`: registered ROB update.
- `cdb_packet`, output, `CDB_PACKET [CDB_SZ-1:0]`: registered `{valid, dest_prn, value}`.
- `rr_ptr_out`, output, `[$clog2(NUM_FU)-1:0]`: current priority pointer (debug).

## Operation
- Handshake is valid/grant.
  - FU holds `fu_req_valid` and a stable `fu_req` until it sees `fu_grant[i]=1` at a clock edge.
  - Dropping valid before grant is illegal.
  - `fu_grant[i]` is never 1 when `fu_req_valid[i]=0`.
- Selection:
  - Scan FUs in order `rr_ptr, rr_ptr+1, …` mod `NUM_FU`.
  - The first `CDB_SZ` valid requesters win; the k-th winner goes to slot k.
  - Slots after the last winner are invalid.
- Pointer update:
  - If at least one grant: `rr_ptr <= (index of last winner + 1) mod NUM_FU`.
  - If no grant: pointer unchanged.
  - Wrap uses explicit compare, not a power-of-2 mask, so `NUM_FU` need not be a power of 2.
- Registered output for slot k:
  - `fu_rob_packet[k].executed = 1`, with `robn`, `branch_taken`, `target_addr` from the winner.
  - `cdb_packet[k].valid = 1`, with `dest_prn` and `value` from the winner.
  - A winner with `dest_prn == 0` (no destination) still occupies the slot, with `cdb_packet[k].valid = 0`.
- Squash:
  - In a cycle with `squash=1`, `fu_grant` is all 0.
  - Next cycle, `fu_rob_packet` and `cdb_packet` are all invalid and `rr_ptr` is unchanged.
  - FUs clear their own requests on squash; the arbiter holds no pending state beyond the output registers.
- Fairness: a continuously asserted request is granted within `ceil(NUM_FU/CDB_SZ)` cycles.

## Timing
- Reset values:
  - `rr_ptr = 0`.
  - All `fu_rob_packet[k].executed = 0`; all `cdb_packet[k].valid = 0`; all payload fields 0.
  - `fu_grant` depends only on inputs plus `rr_ptr`, so it is all 0 during reset.
- Latency: request granted in cycle t appears on the outputs in cycle t+1, for exactly one cycle.
- Output registers reload every cycle. No grant means invalid outputs next cycle; there is no hold.
- Squash and reset are both synchronous. Reset takes precedence over squash.
- Reset mid-operation discards the granted-but-unregistered results. The FUs are also reset.
- Boundary cases:
  - More than `CDB_SZ` valid requests: exactly `CDB_SZ` grants.
  - All `NUM_FU` valid with `CDB_SZ ≥ NUM_FU`: all granted; pointer returns to `(rr_ptr + NUM_FU) mod NUM_FU = rr_ptr`.

## Structure
- Typedefs in `sys_defs.svh`:
  - `CDB_REQ`, `CDB_PACKET`, and the existing `FU_ROB_PACKET`.
  - Constants `` `NUM_FU_CDB `` and `` `CDB_SZ `` (equal to `` `FU_ROB_PACKET_SZ ``).
- Sub-module `rr_multi_picker`, purely combinational:
  - Inputs `req[NUM_FU]`, `ptr`.
  - Outputs `grant[NUM_FU]`, `slot_idx[CDB_SZ]`, `slot_vld[CDB_SZ]`, `next_ptr`.
  - The top level adds the output registers, the pointer register and squash gating.

## Test plan
Configuration for all scenarios: `NUM_FU=4`, `CDB_SZ=2`.

1. **Reset.** Hold reset 2 cycles → all outputs invalid, `rr_ptr=0`, `fu_grant=0` even with `fu_req_valid=4'b1111`.
2. **Rotation.** `fu_req_valid=4'b1111` held 3 cycles → grants `0011`, `1100`, `0011`. `rr_ptr` goes 0 → 2 → 0 → 2. Next-cycle slots carry robn of FU0/1, then FU2/3, then FU0/1.
3. **Sparse wrap.** `rr_ptr=3`, valid `4'b1001` → slot0 = FU3, slot1 = FU0, `rr_ptr` becomes 1.
4. **Hold until grant.** FUs 0–3 valid with robn 5, 6, 7, 8. FU3 keeps valid asserted → FU3 is granted by the 2nd cycle, and robn=8 appears exactly once.
5. **Squash.** Valid `4'b0110` with `squash=1` → `fu_grant=0`; next cycle all outputs invalid; `rr_ptr` unchanged.
6. **No destination.** Single request with `dest_prn=0`, robn=12 → next cycle `fu_rob_packet[0].executed=1`, robn=12, `cdb_packet[0].valid=0`, slot1 invalid.
